obstacle_controller: RTL and testbench

OBSTACLE_CONTROLLER -- requirements
Module: obstacle_controller

---
 rtl/obstacle_controller.sv | 198 +++++++++++++++++++
 tb/tb_obstacle_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_controller.sv
// obstacle_controller
// Spawns a single ground obstacle at the right edge of the screen after a
// pseudo-random delay and scrolls it left once per video frame. When the
// obstacle leaves the screen the score goes up, and the speed rises every
// 8 points. When the obstacle touches the player box it raises hit and then
// freezes for HIT_FRAMES+1 frames before respawning.
//
// Ports
//   clk             system clock (single clock domain)
//   rst             synchronous, active-high reset
//   frame_tick      one-cycle pulse per video frame
//   game_state      00 start, 01 playing, 10 instructions, 11 game over
//   player_x        player left column
//   player_height   player height in rows (0 = never collides)
//   obstacle_x/y    obstacle top-left position (registered)
//   obstacle_width  constant OBS_W (registered)
//   obstacle_height constant OBS_H (registered)
//   hit             one-cycle collision pulse
//   passed          one-cycle pulse when the obstacle clears the screen
//   score           cleared obstacles, saturating at 255
//   speed           current pixels per frame
module obstacle_controller #(
  parameter logic [9:0] SCREEN_W    = 10'd640,
  parameter logic [9:0] OBS_W       = 10'd20,
  parameter logic [9:0] OBS_H       = 10'd20,
  parameter logic [9:0] OBS_Y       = 10'd326,
  parameter logic [9:0] BOX_WIDTH   = 10'd30,
  parameter logic [9:0] BOX_Y_START = 10'd345,
  parameter logic [3:0] SPEED_INIT  = 4'd2,
  parameter logic [3:0] SPEED_MAX   = 4'd8,
  parameter logic [5:0] HIT_FRAMES  = 6'd30,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] game_state,
  input  logic [9:0] player_x,
  input  logic [9:0] player_height,
  output logic [9:0] obstacle_x,
  output logic [9:0] obstacle_y,
  output logic [9:0] obstacle_width,
  output logic [9:0] obstacle_height,
  output logic       hit,
  output logic       passed,
  output logic [7:0] score,
  output logic [3:0] speed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MOVE = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [1:0] GS_PLAYING = 2'b01;

  state_t     state;
  logic [1:0] prev_gs;
  logic [5:0] wait_cnt;
  logic [5:0] hold_cnt;
  logic [7:0] lfsr;

  logic [7:0]  lfsr_next;
  logic        playing;
  logic        entering;
  logic [5:0]  wait_load;
  logic        exits;
  logic [9:0]  step_x;
  logic [7:0]  score_inc;
  logic        overlap;
  logic [10:0] nx;
  logic [10:0] px;
  logic [10:0] player_top;
  logic [10:0] obs_bottom;
  logic        ov_left;
  logic        ov_right;
  logic        ov_vert_a;
  logic        ov_vert_b;

  always_comb begin
    // Galois form of x^8+x^6+x^5+x^4+1, shifting right. The zero guard only
    // matters if the seed parameter is overridden with 0.
    lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    if (lfsr_next == 8'h00) begin
      lfsr_next = LFSR_SEED;
    end

    playing   = (game_state == GS_PLAYING);
    entering  = playing && (prev_gs != GS_PLAYING);
    wait_load = 6'd16 + {1'b0, lfsr[4:0]};

    exits     = (obstacle_x <= {6'd0, speed});
    step_x    = obstacle_x - {6'd0, speed};
    score_inc = score + 8'd1;

    // Overlap is evaluated on the position the obstacle is about to take,
    // in 11 bits so the sums cannot wrap for any 10-bit input.
    nx         = {1'b0, step_x};
    px         = {1'b0, player_x};
    player_top = {1'b0, BOX_Y_START} - {1'b0, player_height} + 11'd1;
    obs_bottom = {1'b0, OBS_Y} + {1'b0, OBS_H} - 11'd1;
    ov_left    = nx < (px + {1'b0, BOX_WIDTH});
    ov_right   = px < (nx + {1'b0, OBS_W});
    ov_vert_a  = {1'b0, OBS_Y} <= {1'b0, BOX_Y_START};
    ov_vert_b  = player_top <= obs_bottom;
    overlap    = ov_left && ov_right && ov_vert_a && ov_vert_b &&
                 (player_height != 10'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      prev_gs         <= 2'b00;
      wait_cnt        <= '0;
      hold_cnt        <= '0;
      lfsr            <= LFSR_SEED;
      obstacle_x      <= SCREEN_W;
      obstacle_y      <= OBS_Y;
      obstacle_width  <= OBS_W;
      obstacle_height <= OBS_H;
      hit             <= 1'b0;
      passed          <= 1'b0;
      score           <= '0;
      speed           <= SPEED_INIT;
    end else begin
      lfsr            <= lfsr_next;
      prev_gs         <= game_state;
      obstacle_y      <= OBS_Y;
      obstacle_width  <= OBS_W;
      obstacle_height <= OBS_H;
      hit             <= 1'b0;
      passed          <= 1'b0;

      if (!playing) begin
        // Score and speed stay untouched so the game-over screen shows them.
        state      <= IDLE;
        obstacle_x <= SCREEN_W;
      end else if (entering) begin
        score      <= '0;
        speed      <= SPEED_INIT;
        state      <= WAIT;
        wait_cnt   <= wait_load;
        obstacle_x <= SCREEN_W;
      end else if (frame_tick) begin
        unique case (state)
          IDLE: begin
            obstacle_x <= SCREEN_W;
          end
          WAIT: begin
            obstacle_x <= SCREEN_W;
            if (wait_cnt == 6'd0) begin
              state <= MOVE;
            end else begin
              wait_cnt <= wait_cnt - 6'd1;
            end
          end
          MOVE: begin
            // Leaving the screen wins over any overlap on the same frame.
            if (exits) begin
              passed     <= 1'b1;
              obstacle_x <= SCREEN_W;
              state      <= WAIT;
              wait_cnt   <= wait_load;
              if (score != 8'hFF) begin
                score <= score_inc;
                if ((score_inc[2:0] == 3'd0) && (speed < SPEED_MAX)) begin
                  speed <= speed + 4'd1;
                end
              end
            end else begin
              obstacle_x <= step_x;
              if (overlap) begin
                hit      <= 1'b1;
                state    <= HOLD;
                hold_cnt <= HIT_FRAMES;
              end
            end
          end
          HOLD: begin
            if (hold_cnt == 6'd0) begin
              obstacle_x <= SCREEN_W;
              state      <= WAIT;
              wait_cnt   <= wait_load;
            end else begin
              hold_cnt <= hold_cnt - 6'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_controller.sv
// Self-checking bench for obstacle_controller: directed scenarios (spawn,
// pass, speed ramp, abort, exit priority, collision) followed by a random
// phase, all checked every cycle against a frame-level behavioural model.
module tb_obstacle_controller;

  localparam int SCR  = 640;
  localparam int OW   = 20;
  localparam int OH   = 20;
  localparam int OY   = 326;
  localparam int BW   = 30;
  localparam int BY   = 345;
  localparam int SPI  = 2;
  localparam int SPM  = 8;
  localparam int HF   = 30;
  localparam int SEED = 'hA5;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic [1:0] game_state;
  logic [9:0] player_x;
  logic [9:0] player_height;
  logic [9:0] obstacle_x;
  logic [9:0] obstacle_y;
  logic [9:0] obstacle_width;
  logic [9:0] obstacle_height;
  logic       hit;
  logic       passed;
  logic [7:0] score;
  logic [3:0] speed;

  int checks   = 0;
  int failures = 0;

  // model: phase 0 idle, 1 waiting to spawn, 2 scrolling, 3 frozen after hit
  int m_phase, m_x, m_score, m_speed, m_wait, m_hold, m_lfsr, m_prev;
  int m_hit, m_passed;

  obstacle_controller dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .game_state      (game_state),
    .player_x        (player_x),
    .player_height   (player_height),
    .obstacle_x      (obstacle_x),
    .obstacle_y      (obstacle_y),
    .obstacle_width  (obstacle_width),
    .obstacle_height (obstacle_height),
    .hit             (hit),
    .passed          (passed),
    .score           (score),
    .speed           (speed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_adv(input int v);
    int n;
    n = v >> 1;
    if ((v & 1) != 0) n = n ^ 'hB8;
    if (n == 0) n = SEED;
    return n;
  endfunction

  function automatic int touches(input int nx, input int px, input int ph);
    int top;
    top = (BY - ph + 1) & 2047;
    return (ph != 0 && nx < px + BW && px < nx + OW && OY <= BY &&
            top <= OY + OH - 1) ? 1 : 0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int lf_now;
    lf_now   = m_lfsr;
    m_hit    = 0;
    m_passed = 0;
    if (rst) begin
      m_phase = 0; m_x = SCR; m_score = 0; m_speed = SPI;
      m_wait = 0; m_hold = 0; m_lfsr = SEED; m_prev = 0;
      return;
    end
    m_lfsr = lfsr_adv(lf_now);
    if (game_state != 2'b01) begin
      m_phase = 0; m_x = SCR;
    end else if (m_prev != 1) begin
      m_score = 0; m_speed = SPI; m_phase = 1; m_x = SCR;
      m_wait = 16 + (lf_now & 31);
    end else if (frame_tick) begin
      if (m_phase == 1) begin
        if (m_wait == 0) m_phase = 2;
        else m_wait--;
      end else if (m_phase == 2) begin
        if (m_x <= m_speed) begin
          m_passed = 1;
          if (m_score < 255) begin
            m_score++;
            if (m_score % 8 == 0 && m_speed < SPM) m_speed++;
          end
          m_x = SCR; m_phase = 1; m_wait = 16 + (lf_now & 31);
        end else begin
          m_x = m_x - m_speed;
          if (touches(m_x, player_x, player_height) != 0) begin
            m_hit = 1; m_phase = 3; m_hold = HF;
          end
        end
      end else if (m_phase == 3) begin
        if (m_hold == 0) begin
          m_x = SCR; m_phase = 1; m_wait = 16 + (lf_now & 31);
        end else m_hold--;
      end
    end
    m_prev = game_state;
  endtask

  task automatic compare_all();
    chk("obstacle_x", int'(obstacle_x), m_x);
    chk("obstacle_y", int'(obstacle_y), OY);
    chk("obstacle_width", int'(obstacle_width), OW);
    chk("obstacle_height", int'(obstacle_height), OH);
    chk("score", int'(score), m_score);
    chk("speed", int'(speed), m_speed);
    chk("hit", int'(hit), m_hit);
    chk("passed", int'(passed), m_passed);
  endtask

  task automatic cyc(input bit r, input bit ft, input logic [1:0] gs,
                     input int px, input int ph);
    rst           = r;
    frame_tick    = ft;
    game_state    = gs;
    player_x      = px[9:0];
    player_height = ph[9:0];
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run_to_score(input int target, input int budget);
    int n;
    n = 0;
    while (int'(score) < target && n < budget) begin
      cyc(0, ($urandom_range(0, 3) != 0), 2'b01, 0, 0);
      n++;
    end
  endtask

  initial begin
    int n;
    int hx;
    int sc;
    logic [1:0] gs;
    m_lfsr = SEED;
    rst = 1'b1; frame_tick = 1'b0; game_state = 2'b00;
    player_x = '0; player_height = '0;

    // reset state
    cyc(1, 0, 2'b00, 0, 0);
    cyc(1, 1, 2'b01, 0, 0);
    chk("rst_x", int'(obstacle_x), 640);
    chk("rst_score", int'(score), 0);
    chk("rst_speed", int'(speed), 2);
    chk("rst_hit", int'(hit), 0);
    chk("rst_passed", int'(passed), 0);

    // spawn: first cycle after reset with 01 counts as entering
    cyc(0, 0, 2'b01, 0, 0);
    n = 0;
    while (int'(obstacle_x) == 640 && n < 100) begin
      cyc(0, 1, 2'b01, 0, 0);
      n++;
    end
    chk("spawn_first_step", int'(obstacle_x), 638);
    chk("spawn_delay_in_range", ((n - 1) >= 17 && (n - 1) <= 48) ? 1 : 0, 1);
    cyc(0, 1, 2'b01, 0, 0);
    chk("spawn_second_step", int'(obstacle_x), 636);

    // first pass
    n = 0;
    while (!passed && n < 3000) begin
      cyc(0, ($urandom_range(0, 1) != 0), 2'b01, 0, 0);
      n++;
    end
    chk("pass_pulse", int'(passed), 1);
    chk("pass_score", int'(score), 1);
    chk("pass_x", int'(obstacle_x), 640);
    cyc(0, 1, 2'b01, 0, 0);
    chk("pass_single_pulse", int'(passed), 0);

    // speed ramp
    run_to_score(8, 20000);
    chk("ramp_score8", int'(score), 8);
    chk("ramp_speed3", int'(speed), 3);
    run_to_score(48, 40000);
    chk("ramp_score48", int'(score), 48);
    chk("ramp_speed8", int'(speed), 8);
    run_to_score(50, 4000);
    chk("ramp_score50", int'(score), 50);
    chk("ramp_speed_capped", int'(speed), 8);

    // abort mid-move, then restart
    n = 0;
    while ((int'(obstacle_x) == 640 || int'(obstacle_x) < 400) && n < 500) begin
      cyc(0, 1, 2'b01, 0, 0);
      n++;
    end
    cyc(0, 0, 2'b11, 0, 0);
    chk("abort_x", int'(obstacle_x), 640);
    chk("abort_score_held", int'(score), 50);
    chk("abort_speed_held", int'(speed), 8);
    cyc(0, 1, 2'b11, 0, 0);
    cyc(0, 0, 2'b01, 0, 0);
    chk("restart_score", int'(score), 0);
    chk("restart_speed", int'(speed), 2);

    // exit priority: reach x=2 with no player, then raise the player
    n = 0;
    while (int'(obstacle_x) != 2 && n < 1000) begin
      cyc(0, 1, 2'b01, 0, 0);
      n++;
    end
    chk("prio_at_2", int'(obstacle_x), 2);
    cyc(0, 1, 2'b01, 0, 30);
    chk("prio_passed", int'(passed), 1);
    chk("prio_no_hit", int'(hit), 0);

    // collision and freeze
    sc = int'(score);
    n = 0;
    while (!hit && n < 1000) begin
      cyc(0, 1, 2'b01, 300, 30);
      n++;
    end
    hx = int'(obstacle_x);
    chk("coll_hit", int'(hit), 1);
    chk("coll_x_edge", (hx <= 329 && hx > 329 - 2) ? 1 : 0, 1);
    n = 0;
    while (int'(obstacle_x) == hx && n < 100) begin
      cyc(0, 1, 2'b01, 300, 30);
      n++;
    end
    chk("coll_frozen_ticks", n, 31);
    chk("coll_respawn_x", int'(obstacle_x), 640);
    chk("coll_score_same", int'(score), sc);

    // random phase
    gs = 2'b01;
    for (int i = 0; i < 6000; i++) begin
      int ph;
      if ($urandom_range(0, 149) == 0) gs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ph = int'($urandom_range(0, 1023));
      else ph = int'($urandom_range(0, 60));
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) != 0), gs,
          int'($urandom_range(0, 639)), ph);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
